// File: rtl/pwm_recover.sv
// pwm_recover: recovers the pulse-width threshold from the rectangle waveform and its sawtooth.
// Build option PWM_RECOVER_AVG_EN: pwm_out becomes the mean of the last 4 published values.
module pwm_recover #(
  parameter int ALIGN_DELAY = 1,
  parameter int W           = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] saw_in,
  input  logic [W-1:0] rect_in,
  output logic [W-1:0] pwm_out,
  output logic         pwm_valid,
  output logic         locked,
  output logic         glitch
);

  // state | meaning
  // SYNC  | after reset, waiting for the first wrap; nothing is published
  // HIGH  | rectangle in its high phase for the current period
  // LOW   | rectangle has fallen; cap holds the saw value at the fall
  typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

  localparam logic [W-1:0] SAW_MAX = '1;

  state_t       state;
  logic [W-1:0] saw_al;
  logic [W-1:0] saw_prev;
  logic [W-1:0] cap;
  logic [W-1:0] pub_val;
  logic [W-1:0] out_val;
  logic         hi;
  logic         hi_q;
  logic         wrap;
  logic         rise;
  logic         pub_en;
  logic         rect_unused;

  generate
    if (ALIGN_DELAY == 0) begin : g_nodly
      assign saw_al = saw_in;
    end else begin : g_dly
      logic [W-1:0] dly [ALIGN_DELAY];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < ALIGN_DELAY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= saw_in;
          for (int i = 1; i < ALIGN_DELAY; i++) dly[i] <= dly[i-1];
        end
      end
      assign saw_al = dly[ALIGN_DELAY-1];
    end
  endgenerate

  // Only the rectangle MSB carries phase information.
  assign hi          = rect_in[W-1];
  assign rect_unused = ^rect_in[W-2:0];
  assign wrap        = saw_al < saw_prev;
  assign rise        = hi & ~hi_q;

  always_comb begin
    pub_en  = 1'b0;
    pub_val = cap;
    if (wrap) begin
      case (state)
        HIGH: begin
          pub_en  = 1'b1;
          pub_val = SAW_MAX;
        end
        LOW: begin
          pub_en  = 1'b1;
          pub_val = cap;
        end
        default: ;
      endcase
    end
  end

`ifdef PWM_RECOVER_AVG_EN
  // Three stored values plus the incoming one form the 4-entry window.
  logic [W-1:0] hist [3];
  logic [W+1:0] sum;

  assign sum     = {2'b00, pub_val} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
  assign out_val = locked ? sum[W+1:2] : pub_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
    end else if (pub_en) begin
      if (!locked) begin
        for (int i = 0; i < 3; i++) hist[i] <= pub_val;
      end else begin
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= pub_val;
      end
    end
  end
`else
  assign out_val = pub_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      cap       <= '0;
      saw_prev  <= '0;
      hi_q      <= 1'b0;
      pwm_out   <= '0;
      pwm_valid <= 1'b0;
      locked    <= 1'b0;
      glitch    <= 1'b0;
    end else begin
      saw_prev  <= saw_al;
      hi_q      <= hi;
      pwm_valid <= 1'b0;
      glitch    <= 1'b0;
      if (pub_en) begin
        pwm_out   <= out_val;
        pwm_valid <= 1'b1;
        locked    <= 1'b1;
      end
      // A wrap closes the old period and re-evaluates hi for the new one.
      if (wrap) begin
        if (!hi) begin
          cap   <= saw_al;
          state <= LOW;
        end else begin
          state <= HIGH;
        end
      end else begin
        case (state)
          HIGH: begin
            if (!hi) begin
              cap   <= saw_al;
              state <= LOW;
            end
          end
          LOW: begin
            if (rise) glitch <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
